uart_cmd_engine: RTL and testbench

Parametrised successor of the board-level UART command parser. It frames received UART bytes into opcode+argument commands and executes them. Commands drive board LEDs, the 7-segment digit registers, the CSoC control pins, and a counted burst of CSoC clock pulses. It reads back CSoC data and answers every command with a reply byte over the UART transmit handshake. It sits between the uart_rx/uart_tx pair and the CSoC pins and digit display driver.

---
 rtl/uart_cmd_engine.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_cmd_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_engine.sv
// UART command engine: frames opcode+argument bytes, drives LEDs, digits, CSoC pins and clock bursts, replies per command.
// Optional build macro CMD_TIMEOUT_EN adds an inter-byte timeout while collecting arguments.
module uart_cmd_engine #(
  parameter int LED_W          = 8,
  parameter int NUM_DIGITS     = 4,
  parameter int CNT_W          = 16,
  parameter int HALF_PERIOD    = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    new_rx_data,
  output logic [7:0]              tx_data,
  output logic                    new_tx_data,
  input  logic                    tx_busy,
  output logic [LED_W-1:0]        leds,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    csoc_clk,
  output logic                    csoc_rstn,
  output logic                    csoc_test_se,
  output logic                    csoc_test_tm,
  input  logic [7:0]              csoc_data_i,
  output logic                    busy,
  output logic                    overrun
);

  localparam int ARG_BYTES = (NUM_DIGITS / 2 > CNT_W / 8) ? NUM_DIGITS / 2 : CNT_W / 8;
  localparam int SR_W      = 8 * ARG_BYTES;
  localparam int PH_W      = $clog2(HALF_PERIOD + 1);
  localparam int DIG_W     = 4 * NUM_DIGITS;

  localparam logic [7:0] OP_L = 8'h4C;
  localparam logic [7:0] OP_D = 8'h44;
  localparam logic [7:0] OP_C = 8'h43;
  localparam logic [7:0] OP_P = 8'h50;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE, S_ARGS, S_EXEC, S_CLKGEN, S_REPLY, S_WAIT_TX
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         op_q, op_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [2:0]         nargs_q, nargs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               csoc_clk_q, csoc_clk_d;
  logic [LED_W-1:0]   leds_q, leds_d;
  logic [DIG_W-1:0]   digits_q, digits_d;
  logic               rstn_q, rstn_d;
  logic               se_q, se_d;
  logic               tm_q, tm_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               new_tx_q, new_tx_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic [DIG_W-1:0]   dig_arg;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]    to_q, to_d;
`endif

  // The first digit byte received ends up in the most significant shifted position.
  for (genvar gi = 0; gi < NUM_DIGITS / 2; gi++) begin : g_dig
    assign dig_arg[8*gi +: 8] = sr_q[8*(NUM_DIGITS/2 - 1 - gi) +: 8];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sr_d       = sr_q;
    nargs_d    = nargs_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    csoc_clk_d = csoc_clk_q;
    leds_d     = leds_q;
    digits_d   = digits_q;
    rstn_d     = rstn_q;
    se_d       = se_q;
    tm_d       = tm_q;
    tx_data_d  = tx_data_q;
    new_tx_d   = 1'b0;
    overrun_d  = 1'b0;
`ifdef CMD_TIMEOUT_EN
    to_d       = to_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (new_rx_data) begin
          op_d = rx_data;
          sr_d = '0;
`ifdef CMD_TIMEOUT_EN
          to_d = TO_W'(TIMEOUT_CYCLES);
`endif
          case (rx_data)
            OP_L, OP_C: begin
              nargs_d = 3'd1;
              state_d = S_ARGS;
            end
            OP_D: begin
              nargs_d = 3'(NUM_DIGITS / 2);
              state_d = S_ARGS;
            end
            OP_P: begin
              nargs_d = 3'(CNT_W / 8);
              state_d = S_ARGS;
            end
            OP_R:    state_d = S_EXEC;
            default: begin
              tx_data_d = CH_E;
              state_d   = S_REPLY;
            end
          endcase
        end
      end

      S_ARGS: begin
        if (new_rx_data) begin
          sr_d    = SR_W'({sr_q, rx_data});
          nargs_d = nargs_q - 3'd1;
`ifdef CMD_TIMEOUT_EN
          to_d    = TO_W'(TIMEOUT_CYCLES);
`endif
          if (nargs_q == 3'd1) state_d = S_EXEC;
        end
`ifdef CMD_TIMEOUT_EN
        else if (to_q <= TO_W'(1)) begin
          tx_data_d = CH_E;
          state_d   = S_REPLY;
        end else begin
          to_d = to_q - TO_W'(1);
        end
`endif
      end

      S_EXEC: begin
        tx_data_d = CH_K;
        state_d   = S_REPLY;
        case (op_q)
          OP_L: leds_d   = sr_q[LED_W-1:0];
          OP_D: digits_d = dig_arg;
          OP_C: begin
            rstn_d = sr_q[0];
            se_d   = sr_q[1];
            tm_d   = sr_q[2];
          end
          OP_P: begin
            if (sr_q[CNT_W-1:0] != '0) begin
              cnt_d      = sr_q[CNT_W-1:0];
              phase_d    = '0;
              csoc_clk_d = 1'b1;
              state_d    = S_CLKGEN;
            end
          end
          default: tx_data_d = csoc_data_i;
        endcase
      end

      // The burst ends on the final falling edge; the count drops at each fall.
      S_CLKGEN: begin
        if (phase_q == PH_W'(HALF_PERIOD - 1)) begin
          phase_d = '0;
          if (csoc_clk_q) begin
            csoc_clk_d = 1'b0;
            if (cnt_q == CNT_W'(1)) begin
              tx_data_d = CH_K;
              state_d   = S_REPLY;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end else begin
            csoc_clk_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_REPLY: begin
        if (!tx_busy) begin
          new_tx_d = 1'b1;
          state_d  = S_WAIT_TX;
        end
      end

      S_WAIT_TX: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (new_rx_data && (state_q == S_EXEC || state_q == S_CLKGEN ||
                        state_q == S_REPLY || state_q == S_WAIT_TX))
      overrun_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      sr_q       <= '0;
      nargs_q    <= '0;
      cnt_q      <= '0;
      phase_q    <= '0;
      csoc_clk_q <= 1'b0;
      leds_q     <= '0;
      digits_q   <= '0;
      rstn_q     <= 1'b0;
      se_q       <= 1'b0;
      tm_q       <= 1'b0;
      tx_data_q  <= '0;
      new_tx_q   <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sr_q       <= sr_d;
      nargs_q    <= nargs_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      csoc_clk_q <= csoc_clk_d;
      leds_q     <= leds_d;
      digits_q   <= digits_d;
      rstn_q     <= rstn_d;
      se_q       <= se_d;
      tm_q       <= tm_d;
      tx_data_q  <= tx_data_d;
      new_tx_q   <= new_tx_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
`ifdef CMD_TIMEOUT_EN
      to_q       <= to_d;
`endif
    end
  end

  assign tx_data      = tx_data_q;
  assign new_tx_data  = new_tx_q;
  assign leds         = leds_q;
  assign digits       = digits_q;
  assign csoc_clk     = csoc_clk_q;
  assign csoc_rstn    = rstn_q;
  assign csoc_test_se = se_q;
  assign csoc_test_tm = tm_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed bench for uart_cmd_engine: command sequences with hand-computed replies, pin states and burst timing.
module tb_uart_cmd_engine;
  localparam int HP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        new_rx_data;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic [7:0]  leds;
  logic [15:0] digits;
  logic        csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
  logic [7:0]  csoc_data_i;
  logic        busy, overrun;

  uart_cmd_engine #(
    .LED_W(8), .NUM_DIGITS(4), .CNT_W(16), .HALF_PERIOD(HP), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .leds(leds), .digits(digits), .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn),
    .csoc_test_se(csoc_test_se), .csoc_test_tm(csoc_test_tm),
    .csoc_data_i(csoc_data_i), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tx_cnt  = 0;
  int tx_ack  = 0;
  int ovr_cnt = 0;
  int rises   = 0;
  int hi_bad  = 0;
  int lo_bad  = 0;
  int run     = 0;
  int last_wait = 0;
  int ovr_base;
  logic clk_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Passive monitor: transmit strobes, overrun pulses and csoc_clk run lengths.
  always @(negedge clk) begin
    if (new_tx_data) tx_cnt++;
    if (overrun) ovr_cnt++;
    if (csoc_clk !== clk_prev) begin
      if (clk_prev) begin
        if (run != HP) hi_bad++;
      end else begin
        rises++;
        if (rises > 1 && run != HP) lo_bad++;
      end
      run = 1;
      clk_prev = csoc_clk;
    end else begin
      run++;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
  endtask

  task automatic wait_reply(input string tag, input logic [7:0] exp);
    bit got = 1'b0;
    last_wait = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (tx_cnt != tx_ack) begin
        got = 1'b1;
        last_wait = i;
        break;
      end
    end
    chk({tag, "_strobe"}, 32'(got), 32'd1);
    chk({tag, "_byte"}, 32'(tx_data), 32'(exp));
    tx_ack = tx_cnt;
    $display("[TB] %s reply 0x%02h after %0d cycles", tag, tx_data, last_wait);
  endtask

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    new_rx_data = 1'b0;
    tx_busy = 1'b0;
    csoc_data_i = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {leds, digits, tx_data}, 32'h0);
    chk("rst_pins", {28'h0, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm}, 32'h0);
    chk("rst_flags", {29'h0, new_tx_data, busy, overrun}, 32'h0);
    rst = 1'b0;

    // 1: LEDs, then an asynchronous reset in the middle of a command
    send(8'h4C); send(8'h11);
    wait_reply("L11", 8'h4B);
    chk("L11_leds", 32'(leds), 32'h11);
    send(8'h4C);
    chk("busy_in_args", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_leds", 32'(leds), 32'h0);
    chk("async_rst_busy", {busy, tx_data}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h4C); send(8'hA5);
    chk("L_before_apply", 32'(leds), 32'h0);
    @(negedge clk);
    chk("L_applied", 32'(leds), 32'hA5);
    wait_reply("LA5", 8'h4B);

    // 2: digits update together after the last argument
    send(8'h44); send(8'h21); send(8'h43);
    chk("D_before_apply", 32'(digits), 32'h0);
    @(negedge clk);
    chk("D_applied", 32'(digits), 32'h4321);
    wait_reply("D", 8'h4B);

    // 3: control pins, then a 3-pulse burst with a dropped byte mid-burst
    send(8'h43); send(8'h07);
    wait_reply("C", 8'h4B);
    chk("C_pins", {28'h0, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm}, 32'h7);
    rises = 0; hi_bad = 0; lo_bad = 0;
    ovr_base = ovr_cnt;
    send(8'h50); send(8'h00); send(8'h03);
    repeat (5) @(negedge clk);
    send(8'h4C);
    wait_reply("P3", 8'h4B);
    chk("P3_pulses", 32'(rises), 32'd3);
    chk("P3_high_len_bad", 32'(hi_bad), 32'd0);
    chk("P3_low_len_bad", 32'(lo_bad), 32'd0);
    chk("P3_overrun_cycles", 32'(ovr_cnt - ovr_base), 32'd1);
    chk("P3_clk_low", 32'(csoc_clk), 32'd0);
    @(negedge clk);
    chk("P3_idle_after", 32'(busy), 32'd0);
    chk("P3_leds_kept", 32'(leds), 32'hA5);

    // 4: readback with the transmitter held busy
    csoc_data_i = 8'h5A;
    tx_busy = 1'b1;
    send(8'h52);
    repeat (20) @(negedge clk);
    #1;
    chk("R_no_strobe_busy", 32'(tx_cnt - tx_ack), 32'd0);
    chk("R_tx_loaded", 32'(tx_data), 32'h5A);
    chk("R_busy", 32'(busy), 32'd1);
    csoc_data_i = 8'hFF;
    tx_busy = 1'b0;
    wait_reply("R", 8'h5A);
    repeat (5) @(negedge clk);
    #1;
    chk("R_single_strobe", 32'(tx_cnt - tx_ack), 32'd0);

    // 5: unknown opcode and a zero-length burst
    send(8'h99);
    wait_reply("unknown", 8'h45);
    rises = 0;
    send(8'h50); send(8'h00); send(8'h00);
    wait_reply("P0", 8'h4B);
    chk("P0_no_pulses", 32'(rises), 32'd0);

    // 6: incomplete command
`ifdef CMD_TIMEOUT_EN
    send(8'h4C);
    wait_reply("timeout", 8'h45);
    chk("timeout_delay_ok", 32'(last_wait >= 95 && last_wait <= 105), 32'd1);
    chk("timeout_leds_kept", 32'(leds), 32'hA5);
`else
    send(8'h4C);
    repeat (150) @(negedge clk);
    #1;
    chk("stall_no_reply", 32'(tx_cnt - tx_ack), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    send(8'h3C);
    @(negedge clk);
    chk("stall_complete_leds", 32'(leds), 32'h3C);
    wait_reply("stall_L", 8'h4B);
`endif

    // 7: reset during a burst abandons it immediately
    send(8'h50); send(8'h00); send(8'h05);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("burst_rst_clk", 32'(csoc_clk), 32'd0);
    chk("burst_rst_busy_rstn", {busy, csoc_rstn}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    chk("burst_rst_no_reply", 32'(tx_cnt - tx_ack), 32'd0);
    chk("burst_rst_clk_idle", {csoc_clk, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
